// File: rtl/wb_port_arbiter.sv
// Writeback register-file port arbiter: pipeline writes win, long-latency results
// wait in a 2-entry in-order FIFO and request a bubble when starved too long.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        LongValid,
  input  logic [4:0]  LongRd,
  input  logic [31:0] LongData,
  output logic        LongReady,
  output logic        RFWriteEn,
  output logic [4:0]  RFWriteAddr,
  output logic [31:0] RFWriteData,
  output logic        StallReq,
  output logic [1:0]  LongCount
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]  rd_mem_q   [2];
  logic [31:0] data_mem_q [2];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        stall_q, stall_d;
  logic        pw_s, push_s, store_s, pop_s;

  // Port arbitration, FIFO bookkeeping and starvation tracking.
  always_comb begin
    pw_s      = RegWriteW & (RdW != 5'd0);
    LongReady = RST_N & (cnt_q != 2'd2);
    push_s    = LongValid & LongReady;
    store_s   = push_s & (LongRd != 5'd0);
    pop_s     = RST_N & ~pw_s & (cnt_q != 2'd0);

    RFWriteEn   = 1'b0;
    RFWriteAddr = 5'd0;
    RFWriteData = 32'd0;
    if (!RST_N) begin
      RFWriteEn = 1'b0;
    end else if (pw_s) begin
      RFWriteEn   = 1'b1;
      RFWriteAddr = RdW;
      RFWriteData = ResultW;
    end else if (cnt_q != 2'd0) begin
      RFWriteEn   = 1'b1;
      RFWriteAddr = rd_mem_q[rptr_q];
      RFWriteData = data_mem_q[rptr_q];
    end else begin
      RFWriteEn = 1'b0;
    end

    wptr_d = wptr_q ^ store_s;
    rptr_d = rptr_q ^ pop_s;

    case ({store_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    if ((cnt_q == 2'd0) || pop_s) begin
      starve_d = 4'd0;
    end else if (starve_q == 4'd15) begin
      starve_d = 4'd15;
    end else begin
      starve_d = starve_q + 4'd1;
    end

    // A pop always clears the request, even if the starve count was high.
    if (pop_s) begin
      stall_d = 1'b0;
    end else if (starve_d >= LIMIT) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // FIFO storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge CLK) begin
    if (store_s) begin
      rd_mem_q[wptr_q]   <= LongRd;
      data_mem_q[wptr_q] <= LongData;
    end else begin
      rd_mem_q[wptr_q]   <= rd_mem_q[wptr_q];
      data_mem_q[wptr_q] <= data_mem_q[wptr_q];
    end
  end

  assign StallReq  = stall_q;
  assign LongCount = cnt_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1..15: consecutive cycles a queued long-latency result may wait before a pipeline bubble is requested.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on posedge CLK.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port RegWriteW  input  1  writeback-stage register-write enable.
REQ-005 SHALL have port RdW  input  5  writeback-stage destination register.
REQ-006 SHALL have port ResultW  input  32  writeback-stage result, already muxed by ResultSrcW.
REQ-007 SHALL have port LongValid  input  1  long-latency unit (divider/CSR) result valid.
REQ-008 SHALL have port LongRd  input  5  long-latency destination register.
REQ-009 SHALL have port LongData  input  32  long-latency result data.
REQ-010 SHALL have port LongReady  output  1  arbiter can accept a long-latency result this cycle.
REQ-011 SHALL have port RFWriteEn  output  1  register-file write enable.
REQ-012 SHALL have port RFWriteAddr  output  5  register-file write address.
REQ-013 SHALL have port RFWriteData  output  32  register-file write data.
REQ-014 SHALL have port StallReq  output  1  registered request to the hazard unit for a writeback bubble.
REQ-015 SHALL have port LongCount  output  2  number of queued long-latency results (0..2).

Function
REQ-016 SHALL hold long-latency results in a 2-entry in-order FIFO with 1-bit read/write pointers that wrap modulo 2, plus a registered count.
REQ-017 SHALL drive LongReady = 1 when count < 2 and RST_N = 1, else 0; at full LongReady = 0 even if a pop occurs the same cycle.
REQ-018 SHALL accept a push on a posedge where LongValid & LongReady; if LongRd = 0 the result is accepted and discarded, with no FIFO entry and no count change.
REQ-019 SHALL implement pipeline write (pw) = RegWriteW & (RdW != 0); pipeline writes always take priority.
REQ-020 SHALL, when pw = 1, drive RFWriteEn = 1, RFWriteAddr = RdW and RFWriteData = ResultW combinationally, with no pop.
REQ-021 SHALL, when pw = 0 and count > 0, drive RFWriteEn = 1 with the FIFO head's address and data, and pop the head at the posedge.
REQ-022 SHALL, when pw = 0 and count = 0, drive RFWriteEn = 0, RFWriteAddr = 0 and RFWriteData = 0.
REQ-023 SHALL not bypass: a result accepted at posedge N writes no earlier than cycle N+1.
REQ-024 SHALL, on simultaneous push and pop, update count by net 0 and keep FIFO order.
REQ-025 SHALL keep a 4-bit starve counter: increment each cycle with count > 0 and no pop, saturating at 15; clear on any pop or when count = 0.
REQ-026 SHALL set StallReq at the posedge where the starve counter's next value >= STARVE_LIMIT, and hold it until the posedge of the next pop, where it clears.
REQ-027 SHALL rely on the hazard unit forcing RegWriteW = 0 in the cycle after StallReq rises; it SHALL not check this assumption.
REQ-028 SHALL drive LongCount from the registered count.

Reset
REQ-029 SHALL, on a posedge with RST_N = 0, clear pointers, count, starve counter and StallReq, and discard FIFO contents, including mid-operation.
REQ-030 SHALL force LongReady = 0 and RFWriteEn = 0 while RST_N = 0, regardless of other inputs.
REQ-031 SHALL, after the first posedge with RST_N = 1 following reset, present LongCount = 0, StallReq = 0 and LongReady = 1.

Verification
REQ-032 SHALL be verified with these scenarios:
- Idle pipe (RegWriteW = 0): push rd = 5, data = 0xDEADBEEF at cycle 0 -> cycle 1 RFWriteEn = 1, addr 5, data 0xDEADBEEF; LongCount 1 -> 0.
- Pipe writes rd = 3 every cycle; push rd = 7 -> no long write; StallReq rises at posedge STARVE_LIMIT (4) after the push; with the bubble applied, rd = 7 is written and StallReq clears.
- Two pushes with the pipe busy -> LongCount = 2, LongReady = 0; third LongValid is not accepted; after one pop, LongReady = 1 the following cycle.
- Full FIFO with pop and LongValid in the same cycle -> no push; count 2 -> 1; the write order of the first two results is preserved.
- Push with LongRd = 0 -> accepted; LongCount stays 0; no RF write. Pipe write with RdW = 0 and FIFO non-empty -> FIFO head written.
- RST_N = 0 for one cycle with 2 queued entries and StallReq = 1 -> next cycle LongCount = 0, StallReq = 0, RFWriteEn = 0; queued data never written.
